// File: rtl/psel_ppart.sv
// psel_ppart: radix-4 Booth partial-product generator for the 16x16 MAC.
// The PSEL recoder turns each 3-bit multiplier window into one-hot select
// lines. The PPART selector then picks +X, +2X, -X or -2X for each row.
// All rows, the correction row and the negation carry-ins are registered.
module psel_ppart (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        unsign_x,
    input  logic        unsign_y,
    input  logic        sub,
    output logic        out_valid,
    output logic [17:0] pp0,
    output logic [17:0] pp1,
    output logic [17:0] pp2,
    output logic [17:0] pp3,
    output logic [17:0] pp4,
    output logic [17:0] pp5,
    output logic [17:0] pp6,
    output logic [17:0] pp7,
    output logic [16:0] pp8,
    output logic [16:0] cin
);

    // One-hot-or-zero Booth digit select lines for a single row.
    typedef struct packed {
        logic p1;
        logic p2;
        logic m1;
        logic m2;
    } psel_t;

    // Recode a window {y[2k+1], y[2k], y[2k-1]} into select lines.
    // A subtract swaps the plus and minus selects, which negates the digit.
    function automatic psel_t psel(input logic [2:0] w, input logic neg);
        psel_t s;
        s = '0;
        unique case (w)
            3'b001, 3'b010: s.p1 = 1'b1;
            3'b011:         s.p2 = 1'b1;
            3'b100:         s.m2 = 1'b1;
            3'b101, 3'b110: s.m1 = 1'b1;
            default:        s = '0;
        endcase
        if (neg) begin
            s = '{p1: s.m1, p2: s.m2, m1: s.p1, m2: s.p2};
        end
        return s;
    endfunction

    logic        x16;
    logic [17:0] x1p, x2p, x1m, x2m;
    logic [16:0] y_ext;
    logic        q8, p8, m8;
    psel_t       sel;

    logic [7:0][17:0] pp_d, pp_q;
    logic [16:0]      pp8_d, pp8_q;
    logic [16:0]      cin_d, cin_q;
    logic             valid_q;

    // Build the extended multiplicand, then recode and select every row.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves a value unassigned and no latch is inferred.
        pp_d  = '0;
        pp8_d = '0;
        cin_d = '0;
        sel   = '0;

        // Two sign copies let +/-2X of the most negative X fit in 18 bits.
        x16 = ~unsign_x & x[15];
        x1p = {x16, x16, x};
        x2p = {x1p[16:0], 1'b0};
        x1m = ~x1p;
        x2m = {x1m[16:0], 1'b0};

        // y[-1] is the implicit zero below the LSB.
        y_ext = {y, 1'b0};

        for (int k = 0; k < 8; k++) begin
            sel = psel(y_ext[2*k +: 3], sub);
            pp_d[k] = ({18{sel.p1}} & x1p) | ({18{sel.p2}} & x2p)
                    | ({18{sel.m1}} & x1m) | ({18{sel.m2}} & x2m);
            // A negated row is a one's complement, so its +1 is deferred to cin.
            cin_d[2*k]     = sel.m1;
            cin_d[2*k + 1] = sel.m2;
        end

        // An unsigned Y with its top bit set needs one extra +/-X row at 2^16.
        q8 = unsign_y & y[15];
        p8 = q8 & ~sub;
        m8 = q8 & sub;
        pp8_d     = ({17{p8}} & x1p[16:0]) | ({17{m8}} & x1m[16:0]);
        cin_d[16] = m8;
    end

    // Capture the rows on in_valid and hold them otherwise. out_valid follows in_valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            pp_q    <= '0;
            pp8_q   <= '0;
            cin_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            valid_q <= in_valid;
            if (in_valid) begin
                pp_q  <= pp_d;
                pp8_q <= pp8_d;
                cin_q <= cin_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign pp0       = pp_q[0];
    assign pp1       = pp_q[1];
    assign pp2       = pp_q[2];
    assign pp3       = pp_q[3];
    assign pp4       = pp_q[4];
    assign pp5       = pp_q[5];
    assign pp6       = pp_q[6];
    assign pp7       = pp_q[7];
    assign pp8       = pp8_q;
    assign cin       = cin_q;

endmodule

// File: tb/tb_psel_ppart.sv
// tb_psel_ppart: directed vectors with hand-computed rows and products.
// A randomized pass checks the arithmetic invariant, output hold and
// asynchronous reset.
module tb_psel_ppart;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        unsign_x = 1'b0;
    logic        unsign_y = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic [17:0] pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7;
    logic [16:0] pp8;
    logic [16:0] cin;

    int total = 0;
    int bad   = 0;

    psel_ppart dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .unsign_x  (unsign_x),
        .unsign_y  (unsign_y),
        .sub       (sub),
        .out_valid (out_valid),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .pp4       (pp4),
        .pp5       (pp5),
        .pp6       (pp6),
        .pp7       (pp7),
        .pp8       (pp8),
        .cin       (cin)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] sx18(input logic [17:0] v);
        return {{22{v[17]}}, v};
    endfunction

    // Weighted sum of the registered outputs, modulo 2^40.
    function automatic logic [39:0] wsum();
        logic [39:0] s;
        s = sx18(pp0)
          + (sx18(pp1) << 2)  + (sx18(pp2) << 4)  + (sx18(pp3) << 6)
          + (sx18(pp4) << 8)  + (sx18(pp5) << 10) + (sx18(pp6) << 12)
          + (sx18(pp7) << 14) + ({{23{pp8[16]}}, pp8} << 16)
          + {23'b0, cin};
        return s;
    endfunction

    // Reference product: (sub ? -1 : +1) * X * Y, modulo 2^40.
    function automatic logic [39:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ua, input logic ub, input logic sb);
        logic [39:0] ae, be, p;
        ae = ua ? {24'b0, a} : {{24{a[15]}}, a};
        be = ub ? {24'b0, b} : {{24{b[15]}}, b};
        p  = ae * be;
        return sb ? (40'd0 - p) : p;
    endfunction

    // Drive one captured operand set, then sample mid-cycle after the edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b,
                         input logic ua, input logic ub, input logic sb);
        x = a; y = b; unsign_x = ua; unsign_y = ub; sub = sb; in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    logic [39:0] last_exp;
    logic        exp_valid;
    logic [15:0] ra, rb;
    logic        rua, rub, rsb, rv;

    initial begin
        // Reset state.
        #12;
        @(negedge CLK);
        check("rst_valid", 40'(out_valid), 40'h0);
        check("rst_pp0", 40'(pp0), 40'h0);
        check("rst_pp7", 40'(pp7), 40'h0);
        check("rst_pp8", 40'(pp8), 40'h0);
        check("rst_cin", 40'(cin), 40'h0);
        RST = 1'b0;

        // Small positive product, add.
        apply(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
        check("t1_valid", 40'(out_valid), 40'h1);
        check("t1_pp0", 40'(pp0), 40'h00003);
        check("t1_pp1", 40'(pp1), 40'h00003);
        check("t1_pp2", 40'(pp2), 40'h0);
        check("t1_cin", 40'(cin), 40'h0);
        check("t1_sum", wsum(), 40'd15);

        // Same operands, subtract.
        apply(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1);
        check("t2_pp0", 40'(pp0), 40'h3FFFC);
        check("t2_pp1", 40'(pp1), 40'h3FFFC);
        check("t2_cin", 40'(cin), 40'h00005);
        check("t2_sum", wsum(), 40'hFF_FFFF_FFF1);

        // Most-negative operands.
        apply(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        check("t3_pp7", 40'(pp7), 40'h0FFFE);
        check("t3_pp0", 40'(pp0), 40'h0);
        check("t3_pp8", 40'(pp8), 40'h0);
        check("t3_cin", 40'(cin), 40'h08000);
        check("t3_sum", wsum(), 40'h00_4000_0000);

        // Unsigned Y correction row.
        apply(16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0);
        check("t4_pp7", 40'(pp7), 40'h3FFFC);
        check("t4_pp8", 40'(pp8), 40'h00001);
        check("t4_cin", 40'(cin), 40'h08000);
        check("t4_sum", wsum(), 40'h8000);

        // All-ones Y.
        apply(16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check("t5_pp0", 40'(pp0), 40'h3EDCB);
        check("t5_pp1", 40'(pp1), 40'h0);
        check("t5_pp7", 40'(pp7), 40'h0);
        check("t5_cin", 40'(cin), 40'h00001);
        check("t5_sum", wsum(), 40'hFF_FFFF_EDCC);

        // Hold while in_valid is low, even though the operands change.
        x = 16'hBEEF; y = 16'h7777; sub = 1'b1; in_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("hold_valid", 40'(out_valid), 40'h0);
        check("hold_pp0", 40'(pp0), 40'h3EDCB);
        check("hold_sum", wsum(), 40'hFF_FFFF_EDCC);

        // Signed Y with its top bit set: no correction row.
        apply(16'h0005, 16'h8000, 1'b0, 1'b0, 1'b0);
        check("t6_pp8", 40'(pp8), 40'h0);
        check("t6_cin16", 40'(cin[16]), 40'h0);
        check("t6_sum", wsum(), 40'hFF_FFFD_8000);

        // Most-negative X with digits +/-2, subtract.
        apply(16'h8000, 16'h0006, 1'b0, 1'b0, 1'b1);
        check("t7_pp0", 40'(pp0), 40'h30000);
        check("t7_pp1", 40'(pp1), 40'h0FFFE);
        check("t7_cin", 40'(cin), 40'h00008);
        check("t7_sum", wsum(), 40'h3_0000);

        // Unsigned Y correction row with subtract.
        apply(16'h0003, 16'h8000, 1'b0, 1'b1, 1'b1);
        check("t8_cin16", 40'(cin[16]), 40'h1);
        check("t8_sum", wsum(), model(16'h0003, 16'h8000, 1'b0, 1'b1, 1'b1));

        // Randomized pass with random in_valid and occasional mid-cycle reset.
        last_exp  = wsum();
        last_exp  = model(16'h0003, 16'h8000, 1'b0, 1'b1, 1'b1);
        exp_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rua = 1'($urandom); rub = 1'($urandom); rsb = 1'($urandom);
            rv  = ($urandom_range(0, 3) != 0);
            x = ra; y = rb; unsign_x = rua; unsign_y = rub; sub = rsb; in_valid = rv;
            if ($urandom_range(0, 99) == 0) begin
                #1 RST = 1'b1;
                #1;
                check("arst_valid", 40'(out_valid), 40'h0);
                check("arst_sum", wsum(), 40'h0);
                check("arst_pp8", 40'(pp8), 40'h0);
                RST = 1'b0;
                last_exp = '0;
            end
            @(posedge CLK);
            if (rv) last_exp = model(ra, rb, rua, rub, rsb);
            exp_valid = rv;
            @(negedge CLK);
            check("rnd_valid", 40'(out_valid), 40'(exp_valid));
            check("rnd_sum", wsum(), last_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
